// File: rtl/key_loader.sv
// key_loader: serial key provisioning for a logic-locked netlist.
// A frame is KEY_WIDTH data bits (MSB first) followed by one even-parity bit.
// The committed key is driven only after a good frame; otherwise the decoy
// key is driven. MAX_FAILS consecutive bad frames lock the block until reset.
module key_loader #(
  parameter int                   KEY_WIDTH = 4,
  parameter logic [KEY_WIDTH-1:0] DECOY_KEY = {KEY_WIDTH{1'b0}},
  parameter int                   MAX_FAILS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 sdata,
  input  logic                 svalid,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 busy,
  output logic                 load_error,
  output logic                 locked_out
);

  localparam int         CNT_W       = $clog2(KEY_WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(KEY_WIDTH);
  localparam logic [3:0] MAX_FAILS_C = 4'(MAX_FAILS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SHIFT   = 2'd1,
    ST_CHECK   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t               state_r;
  logic [KEY_WIDTH-1:0] key_reg_r;
  logic [KEY_WIDTH:0]   shift_r;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic [3:0]           fail_cnt_r;

  // Even parity over the whole frame: a correct frame XORs to zero.
  function automatic logic frame_parity(input logic [KEY_WIDTH:0] frame);
    return ^frame;
  endfunction

  // Load/check/lockout FSM; every output is registered here so nothing on
  // the key port depends combinationally on the serial inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      key_reg_r  <= DECOY_KEY;
      key_out    <= DECOY_KEY;
      key_valid  <= 1'b0;
      busy       <= 1'b0;
      load_error <= 1'b0;
      locked_out <= 1'b0;
      fail_cnt_r <= 4'd0;
      bit_cnt_r  <= {CNT_W{1'b0}};
      shift_r    <= {(KEY_WIDTH+1){1'b0}};
    end else begin
      // load_error is a single-cycle pulse, raised only by a failing CHECK
      load_error <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load_start) begin
            // svalid in this cycle is deliberately not sampled
            state_r   <= ST_SHIFT;
            bit_cnt_r <= {CNT_W{1'b0}};
            shift_r   <= {(KEY_WIDTH+1){1'b0}};
            key_valid <= 1'b0;
            key_out   <= DECOY_KEY;
            busy      <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          busy <= 1'b1;
          if (load_start) begin
            // restart without counting a failure
            state_r   <= ST_SHIFT;
            bit_cnt_r <= {CNT_W{1'b0}};
            shift_r   <= {(KEY_WIDTH+1){1'b0}};
          end else if (svalid) begin
            shift_r   <= {shift_r[KEY_WIDTH-1:0], sdata};
            bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (bit_cnt_r == LAST_BIT) begin
              state_r <= ST_CHECK;
            end else begin
              state_r <= ST_SHIFT;
            end
          end else begin
            // stall: no timeout while the source is idle
            state_r <= ST_SHIFT;
          end
        end
        ST_CHECK: begin
          busy <= 1'b0;
          if (frame_parity(shift_r) == 1'b0) begin
            key_reg_r  <= shift_r[KEY_WIDTH:1];
            key_out    <= shift_r[KEY_WIDTH:1];
            key_valid  <= 1'b1;
            fail_cnt_r <= 4'd0;
            state_r    <= ST_IDLE;
          end else begin
            load_error <= 1'b1;
            fail_cnt_r <= fail_cnt_r + 4'd1;
            key_valid  <= 1'b0;
            key_out    <= DECOY_KEY;
            if ((fail_cnt_r + 4'd1) == MAX_FAILS_C) begin
              state_r    <= ST_LOCKOUT;
              locked_out <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_LOCKOUT: begin
          // terminal until rst_n; all requests are ignored
          state_r    <= ST_LOCKOUT;
          locked_out <= 1'b1;
          key_valid  <= 1'b0;
          key_out    <= DECOY_KEY;
          busy       <= 1'b0;
        end
        default: begin
          state_r    <= ST_IDLE;
          key_valid  <= 1'b0;
          key_out    <= DECOY_KEY;
          busy       <= 1'b0;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed plus randomized bench for key_loader with a frame-level model.
module tb_key_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load_start;
  logic       sdata;
  logic       svalid;
  logic [3:0] key_out;
  logic       key_valid;
  logic       busy;
  logic       load_error;
  logic       locked_out;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference state
  bit       m_valid;
  bit [3:0] m_key;
  int       m_fails;
  bit       m_lock;
  bit       m_busy;
  bit       m_err;

  always #5 clk = ~clk;

  key_loader #(.KEY_WIDTH(4), .DECOY_KEY(4'b0000), .MAX_FAILS(3)) dut (
    .clk(clk), .rst_n(rst_n), .load_start(load_start), .sdata(sdata),
    .svalid(svalid), .key_out(key_out), .key_valid(key_valid), .busy(busy),
    .load_error(load_error), .locked_out(locked_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_key_out"},    {28'd0, key_out},    {28'd0, (m_valid ? m_key : 4'b0000)});
    chk({tag, "_key_valid"},  {31'd0, key_valid},  {31'd0, m_valid});
    chk({tag, "_busy"},       {31'd0, busy},       {31'd0, m_busy});
    chk({tag, "_load_error"}, {31'd0, load_error}, {31'd0, m_err});
    chk({tag, "_locked_out"}, {31'd0, locked_out}, {31'd0, m_lock});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_key = 4'b0000; m_fails = 0;
    m_lock = 1'b0; m_busy = 1'b0; m_err = 1'b0;
  endtask

  // Asserts reset between edges and checks the async effect before any edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0; load_start = 1'b0; svalid = 1'b0; sdata = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    step();
    rst_n = 1'b1;
  endtask

  // load_start pulse with a noisy svalid that must be ignored.
  task automatic start_load(input string tag);
    load_start = 1'b1; svalid = 1'b1; sdata = 1'($urandom);
    step();
    load_start = 1'b0; svalid = 1'b0;
    m_err = 1'b0;
    if (!m_lock) begin
      m_valid = 1'b0;
      m_busy  = 1'b1;
    end
    check_all(tag);
  endtask

  // Feeds nbits of frame (MSB first) with up to max_stall idle cycles per bit.
  task automatic feed_bits(input string tag, input logic [4:0] frame, input int nbits, input int max_stall);
    for (int i = 0; i < nbits; i++) begin
      int stalls;
      stalls = $urandom_range(max_stall, 0);
      for (int s = 0; s < stalls; s++) begin
        svalid = 1'b0; sdata = 1'($urandom);
        step();
        check_all({tag, "_stall"});
      end
      svalid = 1'b1; sdata = frame[4-i];
      step();
      svalid = 1'b0;
      check_all({tag, "_bit"});
    end
  endtask

  // Complete load: start, five bits, CHECK cycle, then the cycle after.
  task automatic load_frame(input string tag, input logic [4:0] frame, input int max_stall);
    int ones;
    start_load({tag, "_start"});
    feed_bits(tag, frame, 5, max_stall);
    // CHECK cycle: requests here are ignored
    load_start = 1'b1; svalid = 1'($urandom); sdata = 1'($urandom);
    step();
    load_start = 1'b0; svalid = 1'b0;
    if (!m_lock) begin
      ones = 0;
      for (int b = 0; b < 5; b++) ones += int'(frame[b]);
      m_busy = 1'b0;
      if (ones % 2 == 0) begin
        m_valid = 1'b1;
        m_key   = frame[4:1];
        m_fails = 0;
      end else begin
        m_valid = 1'b0;
        m_err   = 1'b1;
        m_fails = m_fails + 1;
        if (m_fails == 3) m_lock = 1'b1;
      end
    end
    check_all({tag, "_result"});
    step();
    m_err = 1'b0;
    check_all({tag, "_after"});
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; svalid = 1'b0; sdata = 1'b0;
    model_reset();
    do_reset("t1_reset");

    // 1: good frame, no stalls
    load_frame("t1_good", 5'b10100, 0);
    // 2: bad parity
    load_frame("t2_bad", 5'b10101, 0);

    // 3: three bad frames lock out; good frame ignored; reset recovers
    do_reset("t3_reset");
    load_frame("t3_bad1", 5'b10101, 0);
    load_frame("t3_bad2", 5'b11100, 0);
    load_frame("t3_bad3", 5'b00001, 0);
    load_frame("t3_ignored", 5'b10100, 0);
    do_reset("t3_reset2");
    load_frame("t3_good", 5'b10100, 0);

    // 4: good frame with svalid gaps
    load_frame("t4_gaps", 5'b10100, 2);

    // 5: restart mid-SHIFT does not count as a failure
    do_reset("t5_reset");
    load_frame("t5_bad1", 5'b10101, 0);
    load_frame("t5_bad2", 5'b10101, 1);
    start_load("t5_partial_start");
    feed_bits("t5_partial", 5'b11111, 3, 0);
    load_frame("t5_restart", 5'b01100, 0);

    // 6: new load drops key_valid; async reset mid-SHIFT
    load_frame("t6_good", 5'b10100, 0);
    start_load("t6_drop");
    feed_bits("t6_mid", 5'b11000, 2, 0);
    do_reset("t6_async");
    load_frame("t6_recover", 5'b11000, 1);

    // randomized frames, resetting when locked
    for (int n = 0; n < 24; n++) begin
      logic [4:0] f;
      f = 5'($urandom);
      if (m_lock && ($urandom_range(1, 0) == 1)) do_reset("rnd_reset");
      load_frame("rnd", f, 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so the run always terminates
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
